// File: rtl/pipe_ctrl.sv
// Stall/flush controller for the dual-issue 5-stage pipeline: per-stage enable/clear, divider occupancy, post-exception flush.
// Outputs are combinational from registered state/cnt and current inputs; priority exc > mem > div > load-use > fetch.
module pipe_ctrl #(
  parameter int DIV_LAT = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic i_stall,
  input  logic D_load_use,
  input  logic E_div_start,
  input  logic M_mem_req,
  input  logic d_ready,
  input  logic M_except_master,
  input  logic M_except_slave,
  output logic F_ena,
  output logic D_ena,
  output logic E_ena,
  output logic M_ena,
  output logic D_clear,
  output logic E_clear,
  output logic M_clear,
  output logic W_ena1,
  output logic W_ena2,
  output logic W_clear1,
  output logic W_clear2,
  output logic div_busy,
  output logic div_done,
  output logic div_cancel,
  output logic pc_redirect
);

  localparam int CW = (DIV_LAT > 2) ? $clog2(DIV_LAT) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(DIV_LAT - 2);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DIV_WAIT = 2'd1,
    FLUSH    = 2'd2
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          exc, mem_stall, div_stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    F_ena       = 1'b1;
    D_ena       = 1'b1;
    E_ena       = 1'b1;
    M_ena       = 1'b1;
    D_clear     = 1'b0;
    E_clear     = 1'b0;
    M_clear     = 1'b0;
    W_ena1      = 1'b1;
    W_ena2      = 1'b1;
    W_clear1    = 1'b0;
    W_clear2    = 1'b0;
    div_busy    = (state == DIV_WAIT);
    div_done    = 1'b0;
    div_cancel  = 1'b0;
    pc_redirect = 1'b0;
    state_n     = state;
    cnt_n       = cnt;

    exc       = M_except_master | M_except_slave;
    mem_stall = M_mem_req & ~d_ready;
    div_stall = ((state == IDLE) && E_div_start) ||
                ((state == DIV_WAIT) && (cnt != '0));

    if (exc) begin
      D_clear     = 1'b1;
      E_clear     = 1'b1;
      M_clear     = 1'b1;
      pc_redirect = 1'b1;
      W_clear2    = 1'b1;
      // A slave-only exception still lets the older master instruction commit.
      W_clear1    = M_except_master;
      div_cancel  = (state == DIV_WAIT) || E_div_start;
      state_n     = FLUSH;
      cnt_n       = '0;
    end else if (state == FLUSH) begin
      D_clear = 1'b1;
      state_n = IDLE;
    end else begin
      // The divide counter runs underneath a memory stall; release waits for it.
      if (state == DIV_WAIT) begin
        if (cnt != '0) begin
          cnt_n = cnt - CW'(1);
        end else begin
          div_done = 1'b1;
          if (!mem_stall) state_n = IDLE;
        end
      end

      if (mem_stall) begin
        F_ena    = 1'b0;
        D_ena    = 1'b0;
        E_ena    = 1'b0;
        M_ena    = 1'b0;
        W_clear1 = 1'b1;
        W_clear2 = 1'b1;
      end else if (div_stall) begin
        F_ena   = 1'b0;
        D_ena   = 1'b0;
        E_ena   = 1'b0;
        M_clear = 1'b1;
        if (state == IDLE) begin
          cnt_n   = CNT_LOAD;
          state_n = DIV_WAIT;
        end
      end else if (D_load_use) begin
        F_ena   = 1'b0;
        D_ena   = 1'b0;
        E_clear = 1'b1;
      end else if (i_stall) begin
        F_ena   = 1'b0;
        D_clear = 1'b1;
      end
    end

    if (rst) begin
      F_ena       = 1'b0;
      D_ena       = 1'b0;
      E_ena       = 1'b0;
      M_ena       = 1'b0;
      D_clear     = 1'b0;
      E_clear     = 1'b0;
      M_clear     = 1'b0;
      W_ena1      = 1'b0;
      W_ena2      = 1'b0;
      W_clear1    = 1'b0;
      W_clear2    = 1'b0;
      div_busy    = 1'b0;
      div_done    = 1'b0;
      div_cancel  = 1'b0;
      pc_redirect = 1'b0;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl with DIV_LAT=4; outputs checked as one packed vector at the falling edge.
module tb_pipe_ctrl;

  logic clk, rst;
  logic i_stall, D_load_use, E_div_start, M_mem_req, d_ready;
  logic M_except_master, M_except_slave;
  logic F_ena, D_ena, E_ena, M_ena, D_clear, E_clear, M_clear;
  logic W_ena1, W_ena2, W_clear1, W_clear2;
  logic div_busy, div_done, div_cancel, pc_redirect;

  int checks = 0;
  int fails  = 0;

  pipe_ctrl #(.DIV_LAT(4)) dut (
    .clk(clk), .rst(rst),
    .i_stall(i_stall), .D_load_use(D_load_use), .E_div_start(E_div_start),
    .M_mem_req(M_mem_req), .d_ready(d_ready),
    .M_except_master(M_except_master), .M_except_slave(M_except_slave),
    .F_ena(F_ena), .D_ena(D_ena), .E_ena(E_ena), .M_ena(M_ena),
    .D_clear(D_clear), .E_clear(E_clear), .M_clear(M_clear),
    .W_ena1(W_ena1), .W_ena2(W_ena2), .W_clear1(W_clear1), .W_clear2(W_clear2),
    .div_busy(div_busy), .div_done(div_done), .div_cancel(div_cancel),
    .pc_redirect(pc_redirect)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {F,D,E,M ena}_{D,E,M clear}_{W ena1,2}_{W clear1,2}_{busy,done,cancel,redirect}
  logic [14:0] obs;
  assign obs = {F_ena, D_ena, E_ena, M_ena, D_clear, E_clear, M_clear,
                W_ena1, W_ena2, W_clear1, W_clear2,
                div_busy, div_done, div_cancel, pc_redirect};

  localparam logic [14:0] ZERO     = 15'b0000_000_00_00_0000;
  localparam logic [14:0] DEF      = 15'b1111_000_11_00_0000;
  localparam logic [14:0] DIV_ST   = 15'b0001_001_11_00_0000;
  localparam logic [14:0] DIV_WT   = 15'b0001_001_11_00_1000;
  localparam logic [14:0] DIV_DONE = 15'b1111_000_11_00_1100;
  localparam logic [14:0] MEM_WT   = 15'b0000_000_11_11_1000;
  localparam logic [14:0] MEM_DN   = 15'b0000_000_11_11_1100;
  localparam logic [14:0] MEM_IDL  = 15'b0000_000_11_11_0000;
  localparam logic [14:0] EXC_SLV  = 15'b1111_111_11_01_0001;
  localparam logic [14:0] EXC_MDW  = 15'b1111_111_11_11_1011;
  localparam logic [14:0] EXC_MDS  = 15'b1111_111_11_11_0011;
  localparam logic [14:0] FLUSHV   = 15'b1111_100_11_00_0000;
  localparam logic [14:0] LDUSE    = 15'b0011_010_11_00_0000;
  localparam logic [14:0] FSTALL   = 15'b0111_100_11_00_0000;

  // Check at the falling edge, then advance past the next rising edge.
  task automatic cyc(input string tag, input logic [14:0] exp);
    @(negedge clk);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    i_stall = 1'b0; D_load_use = 1'b0; E_div_start = 1'b0;
    M_mem_req = 1'b0; d_ready = 1'b0;
    M_except_master = 1'b0; M_except_slave = 1'b0;
    @(posedge clk); #1;
    cyc("reset", ZERO);
    rst = 1'b0;
    cyc("idle", DEF);

    // Uncontended divide, then an immediate second divide.
    E_div_start = 1'b1;
    cyc("div_c1", DIV_ST);
    cyc("div_c2", DIV_WT);
    cyc("div_c3", DIV_WT);
    cyc("div_c4", DIV_DONE);
    cyc("b2b_c1", DIV_ST);
    // Memory stall over cycles 2..6 of the second divide.
    M_mem_req = 1'b1; d_ready = 1'b0;
    cyc("mem_c2", MEM_WT);
    cyc("mem_c3", MEM_WT);
    cyc("mem_c4", MEM_DN);
    cyc("mem_c5", MEM_DN);
    cyc("mem_c6", MEM_DN);
    d_ready = 1'b1; E_div_start = 1'b0;
    cyc("mem_rel", DIV_DONE);
    M_mem_req = 1'b0; d_ready = 1'b0;
    cyc("mem_idle", DEF);

    // Slave-only exception.
    M_except_slave = 1'b1;
    cyc("exc_slv", EXC_SLV);
    M_except_slave = 1'b0;
    cyc("exc_slv_flush", FLUSHV);
    cyc("exc_slv_idle", DEF);

    // Master exception on the second DIV_WAIT cycle.
    E_div_start = 1'b1;
    cyc("dx_c1", DIV_ST);
    cyc("dx_c2", DIV_WT);
    M_except_master = 1'b1;
    cyc("dx_exc", EXC_MDW);
    M_except_master = 1'b0; E_div_start = 1'b0;
    cyc("dx_flush", FLUSHV);
    cyc("dx_idle", DEF);
    E_div_start = 1'b1;
    cyc("re_c1", DIV_ST);
    cyc("re_c2", DIV_WT);
    cyc("re_c3", DIV_WT);
    cyc("re_c4", DIV_DONE);
    E_div_start = 1'b0;
    cyc("re_idle", DEF);

    // Exception with a divide just entering E from IDLE.
    E_div_start = 1'b1; M_except_master = 1'b1;
    cyc("exc_divstart", EXC_MDS);
    E_div_start = 1'b0; M_except_master = 1'b0;
    cyc("exc_ds_flush", FLUSHV);

    // Load-use and fetch stalls.
    D_load_use = 1'b1; i_stall = 1'b1;
    cyc("lu_fetch", LDUSE);
    D_load_use = 1'b0;
    cyc("fetch_only", FSTALL);
    M_mem_req = 1'b1; d_ready = 1'b0; D_load_use = 1'b1;
    cyc("mem_over_lu", MEM_IDL);
    M_mem_req = 1'b0; D_load_use = 1'b0; i_stall = 1'b0;
    cyc("quiet", DEF);

    // Reset during DIV_WAIT.
    E_div_start = 1'b1;
    cyc("rd_c1", DIV_ST);
    cyc("rd_c2", DIV_WT);
    rst = 1'b1;
    cyc("rd_rst", ZERO);
    rst = 1'b0; E_div_start = 1'b0;
    cyc("rd_after", DEF);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
